keypad_debounce: RTL and testbench



---
 rtl/keypad_debounce.sv | 156 +++++++++++++++
 tb/tb_keypad_debounce.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronises, debounces and priority-encodes a 20-line keypad
// into a held strobe, an accept/auto-repeat pulse and a 5-bit key code.
`default_nettype none

module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [19:0] buttons,
  output logic [4:0]  keycode,
  output logic        key_strobe,
  output logic        key_pulse,
  output logic        multi_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic [19:0]      r_sync1;
  logic [19:0]      r_sync2;
  state_t           r_state;
  logic [4:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [RPT_W-1:0] r_rpt;
  logic [4:0]       r_keycode;
  logic             r_strobe;
  logic             r_pulse;
  logic             r_multi;

  logic             w_any;
  logic [4:0]       w_code;
  logic             w_multi;
  state_t           w_state_nxt;
  logic [4:0]       w_cand_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [RPT_W-1:0] w_rpt_nxt;
  logic [4:0]       w_keycode_nxt;
  logic             w_strobe_nxt;
  logic             w_pulse_nxt;

  assign w_any   = |r_sync2;
  // Clearing the lowest set bit leaves something only when two or more are set.
  assign w_multi = |(r_sync2 & (r_sync2 - 20'd1));

  always_comb begin
    w_code = 5'd0;
    for (int i = 19; i >= 0; i--) begin
      if (r_sync2[i]) w_code = 5'(i);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_rpt_nxt     = r_rpt;
    w_keycode_nxt = r_keycode;
    w_strobe_nxt  = r_strobe;
    w_pulse_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cand_nxt  = w_code;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_any) begin
          w_state_nxt = S_IDLE;
        end else if (w_code != r_cand) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = S_HELD;
          w_keycode_nxt = r_cand;
          w_strobe_nxt  = 1'b1;
          w_pulse_nxt   = 1'b1;
          w_rpt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!w_any) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (REPEAT_CYCLES > 0) begin
          // The pulse guard only matters for a one-cycle repeat period.
          if (r_rpt == RPT_LAST && !r_pulse) begin
            w_pulse_nxt = 1'b1;
            w_rpt_nxt   = '0;
          end else if (r_rpt != RPT_LAST) begin
            w_rpt_nxt = r_rpt + 1'b1;
          end
        end
      end
      S_RELEASE_WAIT: begin
        if (w_any) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_IDLE;
          w_strobe_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_state   <= S_IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_rpt     <= '0;
      r_keycode <= '0;
      r_strobe  <= 1'b0;
      r_pulse   <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_sync1   <= buttons;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rpt     <= w_rpt_nxt;
      r_keycode <= w_keycode_nxt;
      r_strobe  <= w_strobe_nxt;
      r_pulse   <= w_pulse_nxt;
      r_multi   <= w_multi;
    end
  end

  assign keycode     = r_keycode;
  assign key_strobe  = r_strobe;
  assign key_pulse   = r_pulse;
  assign multi_press = r_multi;

endmodule

`default_nettype wire

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: directed scenarios plus random key traffic checked
// against a run-length model of the debounce rules (two instances: no repeat / repeat 8).
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_debounce;

  localparam int D     = 4;
  localparam int RPT_B = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [19:0] buttons = '0;
  logic [4:0]  kc_a, kc_b;
  logic        st_a, st_b, pu_a, pu_b, mp_a, mp_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0)) dut_a (
    .clk(clk), .nrst(nrst), .buttons(buttons),
    .keycode(kc_a), .key_strobe(st_a), .key_pulse(pu_a), .multi_press(mp_a)
  );

  keypad_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(RPT_B)) dut_b (
    .clk(clk), .nrst(nrst), .buttons(buttons),
    .keycode(kc_b), .key_strobe(st_b), .key_pulse(pu_b), .multi_press(mp_b)
  );

  // Reference: a key is accepted once its code has been seen D+1 samples in a
  // row, released once "no key" has been seen D+1 samples in a row.
  logic [19:0] m_d1 = '0, m_d2 = '0;
  int          m_run_code = -1;
  int          m_run_len = 0;
  logic        m_held = 1'b0;
  logic        m_prev_any = 1'b0;
  logic [4:0]  m_kc = '0;
  logic        m_pu_a = 1'b0, m_pu_b = 1'b0;
  logic        m_multi = 1'b0;
  int          m_rpt_b = 0;

  always @(posedge clk or negedge nrst) begin : model
    logic [19:0] s;
    int code;
    if (!nrst) begin
      m_d1 = '0; m_d2 = '0; m_run_code = -1; m_run_len = 0; m_held = 1'b0;
      m_prev_any = 1'b0; m_kc = '0; m_pu_a = 1'b0; m_pu_b = 1'b0;
      m_multi = 1'b0; m_rpt_b = 0;
    end else begin
      s = m_d2; m_d2 = m_d1; m_d1 = buttons;
      code = -1;
      for (int i = 19; i >= 0; i--) if (s[i]) code = i;
      if (code == m_run_code) begin
        if (m_run_len < 100000) m_run_len++;
      end else begin
        m_run_code = code;
        m_run_len  = 1;
      end
      m_pu_a = 1'b0;
      m_pu_b = 1'b0;
      if (!m_held) begin
        if (code >= 0 && m_run_len == D + 1) begin
          m_held = 1'b1; m_kc = 5'(code); m_pu_a = 1'b1; m_pu_b = 1'b1; m_rpt_b = 0;
        end
      end else if (code < 0) begin
        if (m_run_len == D + 1) m_held = 1'b0;
      end else if (m_prev_any) begin
        if (m_rpt_b == RPT_B - 1) begin
          m_pu_b = 1'b1; m_rpt_b = 0;
        end else begin
          m_rpt_b++;
        end
      end
      m_multi    = ($countones(s) > 1);
      m_prev_any = (code >= 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    buttons = '0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0; buttons = '0;
    repeat (3) tick();
    checks++;
    if ({kc_a, st_a, pu_a, mp_a} !== 8'd0) begin
      $display("FAIL reset_idle: got %h expected 00", {kc_a, st_a, pu_a, mp_a});
      errors++;
    end
    nrst = 1'b1;
    buttons = 20'h00008;
    repeat (10) tick();
    checks++;
    if ({st_a, kc_a} !== {1'b1, 5'd3}) begin
      $display("FAIL pre_reset_held: got st=%0b kc=%0d expected st=1 kc=3", st_a, kc_a);
      errors++;
    end
    nrst = 1'b0;
    #1;
    checks++;
    if ({kc_a, st_a, pu_a, mp_a, kc_b, st_b, pu_b, mp_b} !== 16'd0) begin
      $display("FAIL reset_async: got %h expected 0000", {kc_a, st_a, pu_a, mp_a, kc_b, st_b, pu_b, mp_b});
      errors++;
    end
    tick(); tick();
    nrst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (pu_a !== (i == 7)) begin
        $display("FAIL reset_repress_pulse c%0d: got %0b expected %0b", i, pu_a, (i == 7));
        errors++;
      end
      if (i == 7) begin
        checks++;
        if (kc_a !== 5'd3) begin
          $display("FAIL reset_repress_code: got %0d expected 3", kc_a);
          errors++;
        end
      end
    end
    settle();
  endtask

  task automatic test_clean_press();
    buttons = 20'h1 << 5;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({pu_a, st_a} !== {(i == 7), (i >= 7)}) begin
        $display("FAIL clean_press c%0d: got pu=%0b st=%0b expected pu=%0b st=%0b", i, pu_a, st_a, (i == 7), (i >= 7));
        errors++;
      end
      if (i >= 7) begin
        checks++;
        if (kc_a !== 5'd5) begin
          $display("FAIL clean_code c%0d: got %0d expected 5", i, kc_a);
          errors++;
        end
      end
    end
    buttons = '0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      checks++;
      if ({pu_a, st_a} !== {1'b0, (j < 7)}) begin
        $display("FAIL clean_release c%0d: got pu=%0b st=%0b expected pu=0 st=%0b", j, pu_a, st_a, (j < 7));
        errors++;
      end
    end
    settle();
  endtask

  task automatic test_press_bounce();
    buttons = 20'h4;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (pu_a !== (i == 19)) begin
        $display("FAIL bounce_pulse c%0d: got %0b expected %0b", i, pu_a, (i == 19));
        errors++;
      end
      if (i == 19) begin
        checks++;
        if (kc_a !== 5'd2) begin
          $display("FAIL bounce_code: got %0d expected 2", kc_a);
          errors++;
        end
      end
      if (i < 12) buttons = (((i / 2) % 2) == 0) ? 20'h4 : 20'h0;
      else        buttons = 20'h4;
    end
    settle();
  endtask

  task automatic test_release_bounce();
    int npulse = 0;
    buttons = 20'h1 << 17;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (pu_a === 1'b1) npulse++;
      checks++;
      if (st_a !== (i >= 7 && i < 22)) begin
        $display("FAIL relbounce_strobe c%0d: got %0b expected %0b", i, st_a, (i >= 7 && i < 22));
        errors++;
      end
      if (i == 10) buttons = '0;
      if (i == 12) buttons = 20'h1 << 17;
      if (i == 15) buttons = '0;
    end
    checks++;
    if (npulse != 1) begin
      $display("FAIL relbounce_pulses: got %0d expected 1", npulse);
      errors++;
    end
    checks++;
    if (kc_a !== 5'd17) begin
      $display("FAIL relbounce_code: got %0d expected 17", kc_a);
      errors++;
    end
    settle();
  endtask

  task automatic test_multi();
    buttons = (20'h1 << 12) | (20'h1 << 4);
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if (mp_a !== (i >= 3 && i < 13)) begin
        $display("FAIL multi_flag c%0d: got %0b expected %0b", i, mp_a, (i >= 3 && i < 13));
        errors++;
      end
      checks++;
      if ({pu_a, st_a} !== {(i == 7), (i >= 7 && i < 22)}) begin
        $display("FAIL multi_pulse c%0d: got pu=%0b st=%0b expected pu=%0b st=%0b", i, pu_a, st_a, (i == 7), (i >= 7 && i < 22));
        errors++;
      end
      if (i >= 7) begin
        checks++;
        if (kc_a !== 5'd4) begin
          $display("FAIL multi_code c%0d: got %0d expected 4", i, kc_a);
          errors++;
        end
      end
      if (i == 10) buttons = 20'h1 << 12;
      if (i == 15) buttons = '0;
    end
    settle();
  endtask

  task automatic test_autorepeat();
    buttons = 20'h1 << 9;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (pu_b !== (i >= 7 && ((i - 7) % 8) == 0)) begin
        $display("FAIL repeat_pulse c%0d: got %0b expected %0b", i, pu_b, (i >= 7 && ((i - 7) % 8) == 0));
        errors++;
      end
      if (i >= 7) begin
        checks++;
        if ({kc_b, st_b} !== {5'd9, 1'b1}) begin
          $display("FAIL repeat_code c%0d: got kc=%0d st=%0b expected kc=9 st=1", i, kc_b, st_b);
          errors++;
        end
      end
    end
    settle();
  endtask

  task automatic test_random();
    int n;
    logic [19:0] pat;
    for (int seg = 0; seg < 300; seg++) begin
      n = int'($urandom_range(0, 9));
      pat = '0;
      if (n >= 4) pat[$urandom_range(0, 19)] = 1'b1;
      if (n >= 8) pat[$urandom_range(0, 19)] = 1'b1;
      buttons = pat;
      repeat ($urandom_range(1, 12)) begin
        tick();
        checks++;
        if ({kc_a, st_a, pu_a, mp_a} !== {m_kc, m_held, m_pu_a, m_multi}) begin
          $display("FAIL rand_a: got kc=%0d st=%0b pu=%0b mp=%0b expected kc=%0d st=%0b pu=%0b mp=%0b",
                   kc_a, st_a, pu_a, mp_a, m_kc, m_held, m_pu_a, m_multi);
          errors++;
        end
        checks++;
        if ({kc_b, st_b, pu_b, mp_b} !== {m_kc, m_held, m_pu_b, m_multi}) begin
          $display("FAIL rand_b: got kc=%0d st=%0b pu=%0b mp=%0b expected kc=%0d st=%0b pu=%0b mp=%0b",
                   kc_b, st_b, pu_b, mp_b, m_kc, m_held, m_pu_b, m_multi);
          errors++;
        end
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_multi();
    test_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
